// File: rtl/rr_arbiter_4_pkg.sv
// rtl/rr_arbiter_4_pkg.sv - shared types and constants for the four-way round-robin arbiter
// Purpose: requester index type, output-stage occupancy states, requester count,
//          the post-reset last-grant value and a one-hot encode helper.
// Ports:   none (package).
package arb_pkg;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {S_EMPTY, S_FULL} occ_t;

  localparam int NUM_REQ = 4;

  // Starting from 3 makes requester 0 the first one searched after reset.
  localparam req_idx_t RESET_LAST = 2'd3;

  function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rtl/rr_arbiter_4_if.sv - request/response bundle between requesters, arbiter and downstream
// Purpose: groups the four requester words, their valid/ready pairs and the
//          registered output stage handshake into one interface.
// Signals: i_valid[4], i_data0..3[N]  requester side, driven by master
//          o_ready[4]                 one-hot accept, driven by slave
//          o_valid, o_data[N], o_grant_idx[2]  output stage, driven by slave
//          i_ready                    downstream accept, driven by master
interface rr_arbiter_4_if
  import arb_pkg::*;
#(
  parameter int N = 64
);

  logic [NUM_REQ-1:0] i_valid;
  logic [N-1:0]       i_data0;
  logic [N-1:0]       i_data1;
  logic [N-1:0]       i_data2;
  logic [N-1:0]       i_data3;
  logic [NUM_REQ-1:0] o_ready;
  logic               o_valid;
  logic [N-1:0]       o_data;
  req_idx_t           o_grant_idx;
  logic               i_ready;

  modport master (
    output i_valid, i_data0, i_data1, i_data2, i_data3, i_ready,
    input  o_ready, o_valid, o_data, o_grant_idx
  );

  modport slave (
    input  i_valid, i_data0, i_data1, i_data2, i_data3, i_ready,
    output o_ready, o_valid, o_data, o_grant_idx
  );

endinterface

// File: rtl/rr_arbiter_4_mux.sv
// rtl/rr_arbiter_4_mux.sv - 4:1 payload mux driven by the arbiter winner
// Purpose: selects one of four N-bit words.
// Ports:   i_d0..i_d3 [N] in   candidate words
//          i_sel      [2] in   word index
//          o_d        [N] out  selected word
module mux_4
  import arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic [N-1:0] i_d2,
  input  logic [N-1:0] i_d3,
  input  req_idx_t     i_sel,
  output logic [N-1:0] o_d
);

  always_comb begin
    case (i_sel)
      2'd0:    o_d = i_d0;
      2'd1:    o_d = i_d1;
      2'd2:    o_d = i_d2;
      default: o_d = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - round-robin arbiter with a single-entry registered output stage
// Purpose: picks one of four requesters in strict rotation, accepts its word and
//          holds it in an output register until downstream takes it.
// Ports:   i_clk    in  1  clock, rising edge
//          i_reset  in  1  synchronous active-high reset
//          bus      slave modport of rr_arbiter_4_if (requesters + downstream)
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic  i_clk,
  input  logic  i_reset,
  rr_arbiter_4_if.slave bus
);

  occ_t         state_q, state_d;
  req_idx_t     last_grant_q, last_grant_d;
  req_idx_t     grant_q, grant_d;
  logic [N-1:0] data_q, data_d;

  req_idx_t     winner;
  req_idx_t     cand;
  logic         found;
  logic         any_valid;
  logic         can_accept;
  logic         accept;
  logic [N-1:0] mux_data;

  // Search starts one past the last grant; k=NUM_REQ wraps back onto last_grant itself,
  // so a lone requester can win repeatedly.
  always_comb begin
    winner = last_grant_q;
    cand   = last_grant_q;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant_q + req_idx_t'(k);
      if (!found && bus.i_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Drain and refill may share a cycle; an empty stage never looks at i_ready.
  assign any_valid  = |bus.i_valid;
  assign can_accept = (state_q == S_EMPTY) | bus.i_ready;
  assign accept     = any_valid & can_accept & ~i_reset;

  assign bus.o_ready = accept ? onehot(winner) : '0;

  mux_4 #(.N(N)) u_mux (
    .i_d0  (bus.i_data0),
    .i_d1  (bus.i_data1),
    .i_d2  (bus.i_data2),
    .i_d3  (bus.i_data3),
    .i_sel (winner),
    .o_d   (mux_data)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    data_d       = data_q;
    if (accept) begin
      state_d      = S_FULL;
      last_grant_d = winner;
      grant_d      = winner;
      data_d       = mux_data;
    end else if (state_q == S_FULL && bus.i_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_EMPTY;
      last_grant_q <= RESET_LAST;
      grant_q      <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
    end
  end

  assign bus.o_valid     = (state_q == S_FULL);
  assign bus.o_data      = data_q;
  assign bus.o_grant_idx = grant_q;

endmodule
